// File: rtl/addsub_nibble_seq_if.sv
// Request/response bundle for the nibble-serial add/subtract unit.
// Master issues start/operands; slave returns status and result.
interface addsub_nibble_seq_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] Sum;
  logic         Ovfl;
  logic         Zero;

  modport master (
    output start, A, B, sub,
    input  busy, done, Sum, Ovfl, Zero
  );

  modport slave (
    input  start, A, B, sub,
    output busy, done, Sum, Ovfl, Zero
  );
endinterface

// File: rtl/addsub_nibble_seq.sv
// Signed add/subtract computed one 4-bit slice per clock
// through a single shared nibble adder with registered carry.
module addsub_nibble_seq #(
  parameter int NIBBLES = 4
) (
  input logic                clk,
  input logic                rst_n,
  addsub_nibble_seq_if.slave io
);
  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  opa_q, opa_d;
  logic [W-1:0]  opb_q, opb_d;
  logic [W-1:0]  part_q, part_d;
  logic [W-1:0]  sum_q, sum_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          carry_q, carry_d;
  logic          done_q, done_d;
  logic          ovfl_q, ovfl_d;
  logic          zero_q, zero_d;

  logic [3:0]    sl_a;
  logic [3:0]    sl_b;
  logic [4:0]    sl_r;

  assign sl_a = opa_q[4*cnt_q +: 4];
  assign sl_b = opb_q[4*cnt_q +: 4];
  assign sl_r = {1'b0, sl_a} + {1'b0, sl_b} + {4'b0, carry_q};

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    part_d  = part_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    done_d  = 1'b0;
    ovfl_d  = ovfl_q;
    zero_d  = zero_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (io.start) begin
          opa_d   = io.A;
          opb_d   = io.sub ? ~io.B : io.B;
          carry_d = io.sub;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        part_d[4*cnt_q +: 4] = sl_r[3:0];
        carry_d = sl_r[4];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // top carry is dropped: result is modulo 2^W
          cnt_d   = '0;
          sum_d   = part_d;
          ovfl_d  = (opa_q[W-1] == opb_q[W-1])
                 && (sl_r[3] != opa_q[W-1]);
          zero_d  = (part_d == '0);
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      part_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
      ovfl_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      part_q  <= part_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      done_q  <= done_d;
      ovfl_q  <= ovfl_d;
      zero_q  <= zero_d;
    end
  end

  assign io.busy = (state_q == RUN);
  assign io.done = done_q;
  assign io.Sum  = sum_q;
  assign io.Ovfl = ovfl_q;
  assign io.Zero = zero_q;
endmodule

// File: tb/tb_addsub_nibble_seq.sv
// Directed bench for addsub_nibble_seq (NIBBLES=4).
// Expected values are hand-computed constants.
module tb_addsub_nibble_seq;
  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  logic [15:0] last_sum;

  addsub_nibble_seq_if #(.NIBBLES(4)) bus ();

  addsub_nibble_seq #(.NIBBLES(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .io   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [15:0] a,
                        input logic [15:0] b,
                        input logic s);
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    bus.sub   = s;
    step();
    bus.start = 1'b0;
    bus.A     = 16'($urandom);
    bus.B     = 16'($urandom);
    bus.sub   = 1'($urandom);
  endtask

  task automatic finish_op(input string tag,
                           input logic [15:0] es,
                           input logic eo,
                           input logic ez);
    chk({tag, "_busy0"}, 32'(bus.busy), 32'd1);
    for (int k = 1; k < 4; k++) begin
      step();
      chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
      chk({tag, "_nodone"}, 32'(bus.done), 32'd0);
      chk({tag, "_hold"}, 32'(bus.Sum), 32'(last_sum));
    end
    step();
    chk({tag, "_done"}, 32'(bus.done), 32'd1);
    chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
    chk({tag, "_sum"}, 32'(bus.Sum), 32'(es));
    chk({tag, "_ovfl"}, 32'(bus.Ovfl), 32'(eo));
    chk({tag, "_zero"}, 32'(bus.Zero), 32'(ez));
    last_sum = es;
  endtask

  task automatic run_op(input string tag,
                        input logic [15:0] a,
                        input logic [15:0] b,
                        input logic s,
                        input logic [15:0] es,
                        input logic eo,
                        input logic ez);
    launch(a, b, s);
    finish_op(tag, es, eo, ez);
    step();
    chk({tag, "_pulse"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    int pulses;
    tests     = 0;
    fails     = 0;
    last_sum  = 16'h0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.A     = 16'h0;
    bus.B     = 16'h0;
    bus.sub   = 1'b0;
    #12;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_sum", 32'(bus.Sum), 32'd0);
    chk("rst_ovfl", 32'(bus.Ovfl), 32'd0);
    chk("rst_zero", 32'(bus.Zero), 32'd0);
    rst_n = 1'b1;
    step();

    run_op("add", 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
    run_op("sub_brw", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub_eq", 16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b0, 1'b1);
    run_op("ov_add", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b1, 1'b0);
    run_op("ov_sub", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b0);
    run_op("wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1);

    // start during RUN must be ignored
    launch(16'h0001, 16'h0001, 1'b0);
    bus.start = 1'b1;
    bus.A     = 16'h5555;
    bus.B     = 16'h5555;
    bus.sub   = 1'b0;
    pulses    = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (bus.done === 1'b1) pulses++;
    end
    bus.start = 1'b0;
    chk("prot_sum", 32'(bus.Sum), 32'h0002);
    for (int k = 0; k < 10; k++) begin
      step();
      if (bus.done === 1'b1) pulses++;
      chk("prot_hold", 32'(bus.Sum), 32'h0002);
    end
    chk("prot_pulses", 32'(pulses), 32'd1);
    last_sum = 16'h0002;

    launch(16'h00FF, 16'h0001, 1'b0);
    finish_op("b2b_1", 16'h0100, 1'b0, 1'b0);
    launch(16'h0010, 16'h0020, 1'b1);
    finish_op("b2b_2", 16'hFFF0, 1'b0, 1'b0);
    step();
    chk("b2b_pulse", 32'(bus.done), 32'd0);

    // abort mid-operation with async reset
    launch(16'h1111, 16'h2222, 1'b0);
    step();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_sum", 32'(bus.Sum), 32'd0);
    chk("abort_ovfl", 32'(bus.Ovfl), 32'd0);
    chk("abort_zero", 32'(bus.Zero), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (bus.done === 1'b1) pulses++;
    end
    chk("abort_nopulse", 32'(pulses), 32'd0);
    last_sum = 16'h0000;
    run_op("post_rst", 16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
